// File: rtl/demux1n2_16bit_buf.sv
// rtl/demux1n2_16bit_buf.sv - registered 1-to-2 word demultiplexer with valid/ready and delivery counters
//
// Steers one upstream word per cycle to one of two downstream consumers,
// chosen per word by Sel. Each output channel owns a one-word holding
// register and a wrapping count of words delivered downstream.
//
// Ports:
//   Clock                    rising-edge clock
//   Reset                    asynchronous active-high reset
//   Hyrja        [WIDTH]     input word
//   Sel                      destination of the input word (0 -> Dalja0, 1 -> Dalja1)
//   HyrjaValid               upstream presents a word
//   HyrjaReady               word is accepted this cycle (when HyrjaValid)
//   Dalja0/1     [WIDTH]     held output words
//   Dalja0/1Valid            holding register is full
//   Dalja0/1Ready            downstream consumer takes the held word
//   Numero0/1    [CNT_W]     words delivered per channel, modulo 2^CNT_W

module demux1n2_16bit_buf #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Hyrja,
   input  logic             Sel,
   input  logic             HyrjaValid,
   output logic             HyrjaReady,
   output logic [WIDTH-1:0] Dalja0,
   output logic [WIDTH-1:0] Dalja1,
   output logic             Dalja0Valid,
   output logic             Dalja1Valid,
   input  logic             Dalja0Ready,
   input  logic             Dalja1Ready,
   output logic [CNT_W-1:0] Numero0,
   output logic [CNT_W-1:0] Numero1
);

   localparam logic [CNT_W-1:0] cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic free0;
   logic free1;
   logic accept;
   logic load0;
   logic load1;
   logic drain0;
   logic drain1;

   // A channel can take a new word when it is empty or when its current
   // word leaves on this same edge; the latter gives one word per cycle.
   assign free0 = ~Dalja0Valid | Dalja0Ready;
   assign free1 = ~Dalja1Valid | Dalja1Ready;

   // Ready follows only the selected channel, so a stalled channel never
   // blocks words bound for the other one. Independent of HyrjaValid.
   assign HyrjaReady = Sel ? free1 : free0;

   assign accept = HyrjaValid & HyrjaReady;
   assign load0  = accept & ~Sel;
   assign load1  = accept &  Sel;

   assign drain0 = Dalja0Valid & Dalja0Ready;
   assign drain1 = Dalja1Valid & Dalja1Ready;

   // Channel 0: holding register, full flag, delivery counter.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Dalja0      <= '0;
         Dalja0Valid <= 1'b0;
         Numero0     <= '0;
      end else begin
         // Data is only written on load; after a drain it stays stale but stable.
         if (load0) begin
            Dalja0 <= Hyrja;
         end
         // A load in the drain cycle keeps the flag set.
         if (load0) begin
            Dalja0Valid <= 1'b1;
         end else if (drain0) begin
            Dalja0Valid <= 1'b0;
         end
         if (drain0) begin
            Numero0 <= Numero0 + cnt_one;
         end
      end
   end

   // Channel 1: mirror of channel 0.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         Dalja1      <= '0;
         Dalja1Valid <= 1'b0;
         Numero1     <= '0;
      end else begin
         if (load1) begin
            Dalja1 <= Hyrja;
         end
         if (load1) begin
            Dalja1Valid <= 1'b1;
         end else if (drain1) begin
            Dalja1Valid <= 1'b0;
         end
         if (drain1) begin
            Numero1 <= Numero1 + cnt_one;
         end
      end
   end

endmodule

// File: doc/demux1n2_16bit_buf.md
# demux1n2_16bit_buf

Registered 1-to-2 demultiplexer with valid/ready handshakes. It steers a 16-bit word from one upstream source to one of two downstream consumers, selected per word by `Sel`. It is the distributing counterpart of the 2:1 16-bit selector used in the datapath, for places where one producer feeds two sinks (e.g. write-back toward register file vs. data memory). Each output has a one-word holding register, so the output data is registered, and it keeps a wrapping count of words delivered on each output.

## Interface
- `WIDTH`, default 16: data width of `Hyrja`, `Dalja0`, `Dalja1`.
- `CNT_W`, default 8: width of the delivery counters.

- `Clock`  in  1  sole clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `Hyrja`  in  WIDTH  input word.
- `Sel`  in  1  destination of the current input word: 0 sends it to `Dalja0`, 1 sends it to `Dalja1`.
- `HyrjaValid`  in  1  upstream presents a word.
- `HyrjaReady`  out  1  block accepts the word this cycle.
- `Dalja0`, `Dalja1`  out  WIDTH  held output words.
- `Dalja0Valid`, `Dalja1Valid`  out  1  the matching holding register is full.
- `Dalja0Ready`, `Dalja1Ready`  in  1  the downstream consumer takes the word.
- `Numero0`, `Numero1`  out  CNT_W  words delivered on each output, modulo 2^CNT_W.

## Operation
- Each channel k has a holding register (`Daljak`) and a flag (`DaljakValid`).
- Channel k is free when `~DaljakValid | DaljakReady`.
- `HyrjaReady` = (Sel==0 ? free0 : free1). This is purely combinational from `Sel`, the valid flags and the downstream readies; it does not depend on `HyrjaValid`.
- Accept = `HyrjaValid & HyrjaReady`. On accept, `Hyrja` is loaded into channel `Sel` and its valid flag is set.
- Drain on channel k = `DaljakValid & DaljakReady`:
  - clears `DaljakValid` unless the same cycle also loads a new word into k;
  - increments `Numerok` by 1, wrapping from 2^CNT_W−1 to 0.
- Simultaneous drain and load on the same channel: the new word replaces the old one, valid stays 1, and the counter increments once. This gives full throughput of one word per cycle.
- Load on one channel while the other drains: the two channels are independent and both actions happen.
- The non-selected channel is never written, whatever `Sel` is.
- `Daljak` holds its value when not loaded, including after a drain (the value is stale but stable).
- If `Sel` changes while a word waits unaccepted, the word goes to whichever channel `Sel` names in its accept cycle. Upstream must hold `Hyrja` and `Sel` stable until accept; the block does not check this.
- A blocked channel does not stall the other: a word for a free channel is accepted even if the other channel is full.
- Reset values: `Dalja0`, `Dalja1` = 0; both valids = 0; `Numero0`, `Numero1` = 0.
- `HyrjaReady` is 1 during and after reset, because both channels are empty.
- Reset mid-operation discards held words without counting them.

## Timing
- Latency: a word accepted at edge n appears on `Daljak` with `DaljakValid`=1 right after edge n (visible in cycle n+1).
- A word stays valid until the first edge at which `DaljakReady`=1.
- Throughput: one accept per cycle, sustained while the selected channel is free.
- `Numerok` updates at the drain edge.
- Combinational paths into `HyrjaReady`: from `Sel`, `Dalja0Ready`, `Dalja1Ready` only.
- Reset is asynchronous on assert. Deassertion is expected synchronous to `Clock`; the block has no internal synchronizer.

## Test plan
- Reset with `Hyrja`=16'hFFFF, `HyrjaValid`=1 → all outputs 0 and `HyrjaReady`=1 while `Reset`=1. First edge after release loads 16'hFFFF into the `Sel` channel.
- Alternating routing: words 16'h0001 (Sel=0) and 16'h0002 (Sel=1) on back-to-back cycles, both readies high → `Dalja0`=0001 one cycle later, then `Dalja1`=0002. After the drains `Numero0`=1 and `Numero1`=1.
- Backpressure: `Dalja0Ready`=0, two words with Sel=0 → first held; `HyrjaReady`=0 for the second until `Dalja0Ready`=1. Then the second (16'hBEEF) loads in the same cycle the first drains, and valid never drops.
- Independence: channel 0 full and stalled, word 16'h1234 with Sel=1 → accepted next edge; `Dalja0` unchanged.
- Counter wrap: 256 drains on channel 1 with CNT_W=8 → `Numero1` goes 255→0; `Numero0` stays 0.
- Mid-operation reset: both channels full, assert `Reset` between edges → valids drop to 0 immediately and counters read 0.
